// File: rtl/seg7_pkg.sv
// Shared constants, segment decoder and handshake FSM states for the scanned seven-segment driver.
package seg7_pkg;

  localparam logic [0:6] SEG_BLANK = 7'h7F;
  localparam logic [0:6] SEG_DASH  = 7'b111_1110;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Bit 0 of the result is segment a; literals read a..g left to right.
  function automatic logic [0:6] seg7_decode(input logic [3:0] d);
    logic [0:6] s;
    s = SEG_BLANK;
    case (d)
      4'h0: s = 7'b000_0001;
      4'h1: s = 7'b100_1111;
      4'h2: s = 7'b001_0010;
      4'h3: s = 7'b000_0110;
      4'h4: s = 7'b100_1100;
      4'h5: s = 7'b010_0100;
      4'h6: s = 7'b010_0000;
      4'h7: s = 7'b000_1111;
      4'h8: s = 7'b000_0000;
      4'h9: s = 7'b000_0100;
      4'hA: s = 7'b000_1000;
      4'hB: s = 7'b110_0000;
      4'hC: s = 7'b011_0001;
      4'hD: s = 7'b100_0010;
      4'hE: s = 7'b011_0000;
      4'hF: s = 7'b011_1000;
    endcase
    return s;
  endfunction

  function automatic longint unsigned dec_max(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble: start loads bin, then one shift per cycle for W cycles.
// Latency W cycles after start; busy high throughout, bcd valid once busy falls.
module seg7_bin2bcd #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic [W-1:0] bcd
);

  localparam int CW = $clog2(W);

  logic [W-1:0]   acc_q;
  logic [W-1:0]   sh_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   adj;
  logic [2*W-1:0] shifted;

  always_comb begin
    adj = acc_q;
    for (int k = 0; k < W / 4; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
    shifted = {adj, sh_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      acc_q <= '0;
      sh_q  <= bin;
      cnt_q <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc_q <= shifted[2*W-1:W];
      sh_q  <= shifted[W-1:0];
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) busy <= 1'b0;
    end
  end

  assign bcd = acc_q;

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment driver: captures a value, shows it in hex or decimal with leading-zero blanking.
// Hex digits land 1 cycle after load, decimal W+1 cycles; loads while ready=0 are dropped, not queued.
// SEG_BLINK_EN adds the blink input and a frame-based flash phase.
module seg7_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    mode_dec,
  input  logic                    blank_lz,
`ifdef SEG_BLINK_EN
  input  logic                    blink,
`endif
  output logic                    ready,
  output logic                    ovf,
  output logic [0:6]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  import seg7_pkg::*;

  localparam int W    = 4 * NUM_DIGITS;
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PSW  = $clog2(REFRESH_DIV);
  localparam int CW   = $clog2(W);
  localparam logic [W-1:0] DEC_MAX = W'(dec_max(NUM_DIGITS));

  state_t         state_q, state_d;
  logic           accept, over, start;
  logic [CW-1:0]  bit_cnt_q;
  logic [W-1:0]   cap_value_q;
  logic           cap_blank_q, hex_pend_q;
  logic           conv_busy;
  logic [W-1:0]   bcd;

  logic [0:6]     dig_seg_q [NUM_DIGITS];
  logic [0:6]     dig_seg_d [NUM_DIGITS];
  logic           dig_wr;
  logic [3:0]     nib;
  logic           higher_nz;

  logic [PSW-1:0]  psc_q;
  logic [IDXW-1:0] idx_q;
  logic            psc_tc;
  logic            seg_off;

  seg7_bin2bcd #(.W(W)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value),
    .busy  (conv_busy),
    .bcd   (bcd)
  );

  always_comb begin
    ready   = (state_q == IDLE);
    accept  = load && ready;
    over    = mode_dec && (value > DEC_MAX);
    start   = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && mode_dec) begin
          state_d = over ? DONE : CONV;
          start   = !over;
        end
      end
      CONV:    if (bit_cnt_q == CW'(W - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cap_value_q <= '0;
      cap_blank_q <= 1'b0;
      hex_pend_q  <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state_q    <= state_d;
      hex_pend_q <= accept && !mode_dec;
      if (accept) begin
        cap_value_q <= value;
        cap_blank_q <= blank_lz;
        ovf         <= over;
      end
      if (start) bit_cnt_q <= '0;
      else if (state_q == CONV && conv_busy) bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  // Walk from the top digit down so "any nonzero digit above" is known at each position.
  always_comb begin
    dig_wr    = hex_pend_q || (state_q == DONE);
    higher_nz = 1'b0;
    nib       = 4'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = (state_q == DONE) ? bcd[4*i +: 4] : cap_value_q[4*i +: 4];
      if (state_q == DONE && ovf)
        dig_seg_d[i] = SEG_DASH;
      else if (cap_blank_q && i != 0 && !higher_nz && nib == 4'd0)
        dig_seg_d[i] = SEG_BLANK;
      else
        dig_seg_d[i] = seg7_decode(nib);
      higher_nz = higher_nz | (nib != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig_seg_q[i] <= SEG_BLANK;
    end else if (dig_wr) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig_seg_q[i] <= dig_seg_d[i];
    end
  end

  assign psc_tc = (psc_q == PSW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q <= '0;
      idx_q <= '0;
    end else begin
      psc_q <= psc_tc ? '0 : psc_q + 1'b1;
      if (psc_tc) idx_q <= (idx_q == IDXW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FCW-1:0] frame_cnt_q;
  logic           phase_on_q;
  logic           frame_end;

  assign frame_end = psc_tc && (idx_q == IDXW'(NUM_DIGITS - 1));

  // Phase runs free so turning blink on mid-stream keeps the same cadence.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else if (frame_end) begin
      if (frame_cnt_q == FCW'(BLINK_DIV - 1)) begin
        frame_cnt_q <= '0;
        phase_on_q  <= !phase_on_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign seg_off = blink && !phase_on_q;
`else
  assign seg_off = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n <= SEG_BLANK;
      an_n  <= '1;
    end else begin
      an_n  <= ~(NUM_DIGITS'(1) << idx_q);
      seg_n <= seg_off ? SEG_BLANK : dig_seg_q[idx_q];
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized and directed checks of seg7_scan_display against an arithmetic digit model.
module tb_seg7_scan_display;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BD = 2;
  localparam int W  = 4 * ND;

  logic          clk = 1'b0;
  logic          reset, load, mode_dec, blank_lz;
  logic [W-1:0]  value;
  logic          ready, ovf;
  logic [0:6]    seg_n;
  logic [ND-1:0] an_n;
`ifdef SEG_BLINK_EN
  logic          blink;
`endif

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg7_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
`ifdef SEG_BLINK_EN
    .blink    (blink),
`endif
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .value    (value),
    .mode_dec (mode_dec),
    .blank_lz (blank_lz),
    .ready    (ready),
    .ovf      (ovf),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  always #5 clk = ~clk;

  function automatic logic [ND-1:0][6:0] model(input int unsigned v, input bit dec, input bit bl);
    logic [ND-1:0][6:0] r;
    int unsigned base, p, dmax;
    base = dec ? 10 : 16;
    dmax = 10 ** ND - 1;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      if (dec && v > dmax)             r[i] = 7'b1111110;
      else if (bl && i > 0 && v / p == 0) r[i] = 7'h7F;
      else                             r[i] = seg_tab[(v / p) % base];
      p = p * base;
    end
    return r;
  endfunction

  task automatic do_load(input logic [W-1:0] v, input bit dec, input bit bl, output int busy);
    int guard;
    guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    load = 1'b1; value = v; mode_dec = dec; blank_lz = bl;
    @(negedge clk);
    load = 1'b0;
    busy = 0;
    while (ready !== 1'b1 && busy < 200) begin
      busy++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_display(input string tag, input logic [ND-1:0][6:0] exp, input bit exp_ovf);
    logic [ND-1:0][6:0] got;
    bit [ND-1:0] seen;
    logic [ND-1:0] oh;
    seen = '0;
    got  = '0;
    for (int c = 0; c < ND * RD + 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        oh = ~(ND'(1) << d);
        if (an_n === oh) begin
          got[d]  = seg_n;
          seen[d] = 1'b1;
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (!seen[d] || got[d] !== exp[d]) begin
        errors++;
        $display("FAIL %s digit%0d seen=%0b got=%b expected=%b", tag, d, seen[d], got[d], exp[d]);
      end
    end
    checks++;
    if (ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s ovf got=%b expected=%b", tag, ovf, exp_ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; value = '0; mode_dec = 1'b0; blank_lz = 1'b0;
`ifdef SEG_BLINK_EN
    blink = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (seg_n !== 7'h7F || an_n !== 4'hF || ready !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset got seg=%h an=%h ready=%b ovf=%b expected seg=7f an=f ready=1 ovf=0",
               seg_n, an_n, ready, ovf);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan_order();
    logic [ND-1:0] exp;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      exp = ~(ND'(1) << (((n - 1) / RD) % ND));
      checks++;
      if (an_n !== exp) begin
        errors++;
        $display("FAIL scan_order cycle%0d an_n got=%h expected=%h", n, an_n, exp);
      end
    end
  endtask

  task automatic test_hex();
    int busy;
    do_load(16'h1A3F, 1'b0, 1'b0, busy);
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL hex_ready busy cycles got=%0d expected=0", busy);
    end
    check_display("hex_1A3F", {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}, 1'b0);
  endtask

  task automatic test_decimal();
    int busy;
    do_load(16'd42, 1'b1, 1'b1, busy);
    checks++;
    if (busy !== 17) begin
      errors++;
      $display("FAIL dec_busy cycles got=%0d expected=17", busy);
    end
    check_display("dec_42", {7'h7F, 7'h7F, 7'b1001100, 7'b0010010}, 1'b0);
  endtask

  task automatic test_overflow();
    int busy;
    do_load(16'd12345, 1'b1, 1'b0, busy);
    checks++;
    if (busy !== 1) begin
      errors++;
      $display("FAIL ovf_busy cycles got=%0d expected=1", busy);
    end
    check_display("dec_overflow", {4{7'b1111110}}, 1'b1);
    do_load(16'h0000, 1'b0, 1'b1, busy);
    check_display("hex_zero_blank", {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 1'b0);
  endtask

  task automatic test_random();
    int busy, exp_busy;
    int unsigned v;
    bit dec, bl;
    for (int t = 0; t < 12; t++) begin
      dec = 1'($urandom_range(0, 1));
      bl  = 1'($urandom_range(0, 1));
      v   = $urandom_range(0, 65535) >> $urandom_range(0, 15);
      if (dec && $urandom_range(0, 2) != 0) v = v % 10000;
      exp_busy = !dec ? 0 : (v > 9999) ? 1 : 17;
      do_load(W'(v), dec, bl, busy);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL random%0d busy got=%0d expected=%0d", t, busy, exp_busy);
      end
      check_display($sformatf("random%0d v=%0d dec=%0b bl=%0b", t, v, dec, bl),
                    model(v, dec, bl), dec && v > 9999);
    end
  endtask

  task automatic test_load_during_conv();
    int guard;
    load = 1'b1; value = 16'd1234; mode_dec = 1'b1; blank_lz = 1'b0;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    load = 1'b1; value = 16'h0009; mode_dec = 1'b0; blank_lz = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got=%b expected=0", ready);
    end
    guard = 0;
    while (ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check_display("load_ignored", model(1234, 1'b1, 1'b0), 1'b0);
  endtask

  task automatic test_reset_mid_conv();
    @(negedge clk);
    load = 1'b1; value = 16'd5678; mode_dec = 1'b1; blank_lz = 1'b0;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || seg_n !== 7'h7F || an_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_mid_conv got ready=%b seg=%h an=%h expected ready=1 seg=7f an=f",
               ready, seg_n, an_n);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_display("after_abort", {4{7'h7F}}, 1'b0);
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    logic [6:0] exp;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; blink = 1'b1;
    load = 1'b1; value = 16'h8888; mode_dec = 1'b0; blank_lz = 1'b0;
    @(negedge clk);
    load = 1'b0;
    for (int n = 2; n <= 160; n++) begin
      @(negedge clk);
      if (n >= 4) begin
        exp = (((n - 1) / (ND * RD * BD)) % 2 == 1) ? 7'h7F : 7'h00;
        checks++;
        if (seg_n !== exp || an_n === 4'hF) begin
          errors++;
          $display("FAIL blink cycle%0d seg got=%h expected=%h an=%h", n, seg_n, exp, an_n);
        end
      end
    end
    blink = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      checks++;
      if (seg_n !== 7'h00) begin
        errors++;
        $display("FAIL blink_off cycle%0d seg got=%h expected=00", n, seg_n);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan_order();
    test_hex();
    test_decimal();
    test_overflow();
    test_random();
    test_load_during_conv();
    test_reset_mid_conv();
`ifdef SEG_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
